// File: rtl/sysbus_pkg.sv
// Shared constants and state encoding for the system-bus memory responder.
package sysbus_pkg;
  localparam int BUS_DATA_WIDTH = 64;
  localparam int BUS_TAG_WIDTH  = 13;
  localparam int BEATS          = 8;

  localparam logic SYSBUS_WRITE = 1'b1;
  localparam logic SYSBUS_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACK   = 3'd1,
    WDATA = 3'd2,
    WACK  = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } sysbus_state_e;
endpackage

// File: rtl/sysbus_line_ram.sv
// Full-line store: synchronous whole-line write, combinational read, cleared on reset.
module sysbus_line_ram #(
  parameter int INDEX_BITS = 5,
  parameter int NUM_LINES  = 32,
  parameter int LINE_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] waddr,
  input  logic [LINE_WIDTH-1:0] wdata,
  input  logic [INDEX_BITS-1:0] raddr,
  output logic [LINE_WIDTH-1:0] rdata
);
  logic [LINE_WIDTH-1:0] mem_r [NUM_LINES];

  // line storage update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side responder: one outstanding line request, 8-beat reads after a
// programmable latency, 8-beat writes committed atomically to the line store.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = sysbus_pkg::BUS_DATA_WIDTH,
  parameter int BUS_TAG_WIDTH  = sysbus_pkg::BUS_TAG_WIDTH,
  parameter int OFFSET         = 6,
  parameter int INDEX_BITS     = 5,
  parameter int NUM_LINES      = 32,
  parameter int BEATS          = sysbus_pkg::BEATS,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reqcyc,
  output logic                      reqack,
  input  logic [BUS_DATA_WIDTH-1:0] req,
  input  logic [BUS_TAG_WIDTH-1:0]  reqtag,
  output logic                      respcyc,
  input  logic                      respack,
  output logic [BUS_DATA_WIDTH-1:0] resp,
  output logic [BUS_TAG_WIDTH-1:0]  resptag
);
  import sysbus_pkg::*;

  localparam int LINE_WIDTH = BUS_DATA_WIDTH * BEATS;
  localparam int BEAT_W     = $clog2(BEATS);
  localparam int LAT_W      = 16;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  sysbus_state_e             state_r, state_n;
  logic [INDEX_BITS-1:0]     idx_r, idx_n;
  logic [BUS_TAG_WIDTH-1:0]  tag_r, tag_n;
  logic [BEAT_W-1:0]         beat_r, beat_n, beat_inc_s;
  logic [LAT_W-1:0]          lat_r, lat_n;
  logic [LINE_WIDTH-1:0]     wbuf_r, wbuf_n;
  logic                      reqack_r, reqack_n;
  logic                      respcyc_r, respcyc_n;
  logic [BUS_DATA_WIDTH-1:0] resp_r, resp_n;
  logic [BUS_TAG_WIDTH-1:0]  resptag_r, resptag_n;
  logic                      we_s;
  logic [LINE_WIDTH-1:0]     line_s;

  assign beat_inc_s = beat_r + BEAT_W'(1);

  sysbus_line_ram #(
    .INDEX_BITS(INDEX_BITS),
    .NUM_LINES (NUM_LINES),
    .LINE_WIDTH(LINE_WIDTH)
  ) u_line_ram (
    .clk  (clk),
    .reset(reset),
    .we   (we_s),
    .waddr(idx_r),
    .wdata(wbuf_r),
    .raddr(idx_r),
    .rdata(line_s)
  );

  // next-state and next-output decode
  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    tag_n     = tag_r;
    beat_n    = beat_r;
    lat_n     = lat_r;
    wbuf_n    = wbuf_r;
    reqack_n  = 1'b0;
    respcyc_n = 1'b0;
    resp_n    = resp_r;
    resptag_n = resptag_r;
    we_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (reqcyc) begin
          idx_n    = req[OFFSET+INDEX_BITS-1:OFFSET];
          tag_n    = reqtag;
          reqack_n = 1'b1;
          state_n  = ACK;
        end else begin
          state_n = IDLE;
        end
      end
      ACK: begin
        beat_n = '0;
        if (tag_r[BUS_TAG_WIDTH-1] == SYSBUS_WRITE) begin
          state_n = WDATA;
        end else if (READ_LATENCY == 0) begin
          respcyc_n = 1'b1;
          resp_n    = line_s[0 +: BUS_DATA_WIDTH];
          resptag_n = tag_r;
          state_n   = RESP;
        end else begin
          lat_n   = LAT_W'(READ_LATENCY - 1);
          state_n = WAIT;
        end
      end
      WDATA: begin
        if (reqcyc) begin
          wbuf_n[int'(beat_r) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = req;
          reqack_n = 1'b1;
          state_n  = WACK;
        end else begin
          state_n = WDATA;
        end
      end
      WACK: begin
        if (beat_r == LAST_BEAT) begin
          // the final beat is already in the buffer, so the whole line commits at once
          we_s    = 1'b1;
          beat_n  = '0;
          state_n = IDLE;
        end else begin
          beat_n  = beat_inc_s;
          state_n = WDATA;
        end
      end
      WAIT: begin
        if (lat_r == LAT_W'(0)) begin
          respcyc_n = 1'b1;
          resp_n    = line_s[0 +: BUS_DATA_WIDTH];
          resptag_n = tag_r;
          state_n   = RESP;
        end else begin
          lat_n   = lat_r - LAT_W'(1);
          state_n = WAIT;
        end
      end
      RESP: begin
        if (respack && (beat_r == LAST_BEAT)) begin
          beat_n  = '0;
          state_n = IDLE;
        end else if (respack) begin
          respcyc_n = 1'b1;
          beat_n    = beat_inc_s;
          resp_n    = line_s[int'(beat_inc_s) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
          state_n   = RESP;
        end else begin
          respcyc_n = 1'b1;
          state_n   = RESP;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state and registered-output update
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= '0;
      tag_r     <= '0;
      beat_r    <= '0;
      lat_r     <= '0;
      wbuf_r    <= '0;
      reqack_r  <= 1'b0;
      respcyc_r <= 1'b0;
      resp_r    <= '0;
      resptag_r <= '0;
    end else begin
      state_r   <= state_n;
      idx_r     <= idx_n;
      tag_r     <= tag_n;
      beat_r    <= beat_n;
      lat_r     <= lat_n;
      wbuf_r    <= wbuf_n;
      reqack_r  <= reqack_n;
      respcyc_r <= respcyc_n;
      resp_r    <= resp_n;
      resptag_r <= resptag_n;
    end
  end

  assign reqack  = reqack_r;
  assign respcyc = respcyc_r;
  assign resp    = resp_r;
  assign resptag = resptag_r;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: a latency-4 instance for the main
// traffic and a latency-0 instance for the minimum-latency case.
module tb_sysbus_mem_responder;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset;
  logic reqcyc, reqack, respcyc, respack;
  logic [63:0] req, resp;
  logic [12:0] reqtag, resptag;
  logic reqcyc0, reqack0, respcyc0, respack0;
  logic [63:0] req0, resp0;
  logic [12:0] reqtag0, resptag0;

  int checks = 0;
  int failures = 0;
  logic [63:0]  exp_q [$];
  logic [511:0] model [32];
  logic [63:0]  wdata_a [8];

  always #5 clk = ~clk;

  sysbus_mem_responder #(.READ_LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .reqcyc(reqcyc), .reqack(reqack), .req(req),
    .reqtag(reqtag), .respcyc(respcyc), .respack(respack), .resp(resp), .resptag(resptag)
  );

  sysbus_mem_responder #(.READ_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .reqcyc(reqcyc0), .reqack(reqack0), .req(req0),
    .reqtag(reqtag0), .respcyc(respcyc0), .respack(respack0), .resp(resp0), .resptag(resptag0)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_line(input logic [63:0] addr, input logic [12:0] tag, input int hold_beat,
                           input bit issued, input bit chain,
                           input logic [63:0] c_addr, input logic [12:0] c_tag);
    logic [511:0] line;
    logic [63:0]  hold_val;
    logic [63:0]  exp;
    int beat, n, held, acks;
    bit done, first;
    line = model[addr[10:6]];
    exp_q.delete();
    for (int b = 0; b < 8; b++) exp_q.push_back(line[64*b +: 64]);
    if (!issued) begin
      tick();
      reqcyc = 1'b1; req = addr; reqtag = tag;
      @(negedge clk);
      tick();
      @(negedge clk);
      check_eq("rd_addr_ack", reqack, 1);
    end
    tick();
    reqcyc = 1'b0;
    n = 2; beat = 0; held = 0; acks = 0; done = 0; first = 1; hold_val = '0;
    while (!done && n < 200) begin
      respack = respcyc && !((beat == hold_beat) && (held < 5));
      if (chain && respack && beat == 7) begin
        reqcyc = 1'b1; req = c_addr; reqtag = c_tag;
      end
      @(negedge clk);
      if (reqack) acks++;
      if (respcyc && first) begin
        check_eq("first_beat_lat", n, 2 + LAT);
        first = 0;
      end
      if (respcyc) check_eq("resptag", resptag, tag);
      if (respcyc && !respack) begin
        if (held > 0) check_eq("hold_stable", resp, hold_val);
        hold_val = resp;
        held++;
      end
      if (respcyc && respack) begin
        exp = exp_q.pop_front();
        check_eq("rd_beat", resp, exp);
        if (beat == 7) done = 1;
        beat++;
      end
      tick();
      n++;
    end
    respack = 1'b0;
    check_eq("rd_done", done, 1);
    check_eq("rd_no_extra_ack", acks, 0);
    @(negedge clk);
    check_eq("respcyc_drop", respcyc, 0);
    if (chain) begin
      check_eq("chain_idle_noack", reqack, 0);
      tick();
      @(negedge clk);
      check_eq("chain_ack", reqack, 1);
    end
  endtask

  task automatic write_line(input logic [63:0] addr, input logic [12:0] tag, input int reset_at);
    logic [511:0] line;
    int acks;
    tick();
    reqcyc = 1'b1; req = addr; reqtag = tag;
    @(negedge clk);
    tick();
    @(negedge clk);
    check_eq("wr_addr_ack", reqack, 1);
    acks = 0; line = '0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c % 2 == 0) begin
        req = wdata_a[c/2];
        line[64*(c/2) +: 64] = wdata_a[c/2];
      end
      if (reset_at >= 0 && c == 2*reset_at) reset = 1'b1;
      if (reset_at >= 0 && c == 2*reset_at + 1) begin
        reset = 1'b0; reqcyc = 1'b0;
      end
      @(negedge clk);
      if (reset_at >= 0 && c == 2*reset_at + 1) begin
        check_eq("rst_reqack", reqack, 0);
        check_eq("rst_respcyc", respcyc, 0);
        check_eq("rst_resp", resp, 0);
        check_eq("rst_resptag", resptag, 0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        return;
      end
      if (reqack) acks++;
      check_eq("wr_ack_phase", reqack, c % 2);
    end
    tick();
    reqcyc = 1'b0;
    @(negedge clk);
    check_eq("wr_ack_count", acks, 8);
    check_eq("wr_idle_noack", reqack, 0);
    model[addr[10:6]] = line;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    reqcyc = 1'b0; req = '0; reqtag = '0; respack = 1'b0;
    reqcyc0 = 1'b0; req0 = '0; reqtag0 = '0; respack0 = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_reqack", reqack, 0);
    check_eq("reset_respcyc", respcyc, 0);
    check_eq("reset_resp", resp, 0);
    check_eq("reset_resptag", resptag, 0);
    tick();
    reset = 1'b0;

    // cleared line read
    read_line(64'h1040, 13'h0005, -1, 1'b0, 1'b0, 64'h0, 13'h0);

    // write then read back, with a 5-cycle respack stall on beat 3
    for (int b = 0; b < 8; b++) wdata_a[b] = 64'h11 * (b + 1);
    write_line(64'h2000, 13'h1003, -1);
    read_line(64'h2000, 13'h0002, 3, 1'b0, 1'b0, 64'h0, 13'h0);

    // aliasing and offset-insensitivity, with a back-to-back held request
    for (int b = 0; b < 8; b++) wdata_a[b] = {$urandom(), $urandom()};
    write_line(64'h0040, 13'h1001, -1);
    read_line(64'h0840, 13'h0009, -1, 1'b0, 1'b1, 64'h0078, 13'h000a);
    read_line(64'h0078, 13'h000a, -1, 1'b1, 1'b0, 64'h0, 13'h0);

    // reset in the middle of a write burst clears everything
    for (int b = 0; b < 8; b++) wdata_a[b] = 64'hA5A5_0000_0000_0000 | 64'(b);
    write_line(64'h3000, 13'h1004, 4);
    read_line(64'h3000, 13'h0006, -1, 1'b0, 1'b0, 64'h0, 13'h0);
    read_line(64'h2000, 13'h0007, -1, 1'b0, 1'b0, 64'h0, 13'h0);

    // zero-latency instance: first beat two cycles after the request
    tick();
    reqcyc0 = 1'b1; req0 = 64'h0; reqtag0 = 13'h0007;
    @(negedge clk);
    tick();
    @(negedge clk);
    check_eq("lat0_ack", reqack0, 1);
    tick();
    reqcyc0 = 1'b0; respack0 = 1'b1;
    @(negedge clk);
    check_eq("lat0_first_beat", respcyc0, 1);
    check_eq("lat0_resptag", resptag0, 13'h0007);
    check_eq("lat0_beat", resp0, 0);
    for (int b = 1; b < 8; b++) begin
      tick();
      @(negedge clk);
      check_eq("lat0_respcyc", respcyc0, 1);
      check_eq("lat0_beat", resp0, 0);
    end
    tick();
    respack0 = 1'b0;
    @(negedge clk);
    check_eq("lat0_drop", respcyc0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
